// File: rtl/vram_pkg.sv
// vram_pkg: shared state encoding and widths for the VRAM arbiter
package vram_pkg;
  localparam int VRAM_ADDR_W = 13;
  localparam int STALL_CNT_W = 16;
  typedef enum logic [1:0] {IDLE, PEND, CPU_RD, ACK} arb_state_t;
endpackage

// File: rtl/vid_fetch_pipe.sv
// vid_fetch_pipe: fixed two-cycle video fetch pipeline over the registered VRAM
module vid_fetch_pipe (
  input  logic       pixel_clock,
  input  logic       reset,
  input  logic       vid_rd,
  input  logic [7:0] ram_rdata,
  output logic [7:0] vid_data,
  output logic       vid_valid
);
  logic rd_q;
  always_ff @(posedge pixel_clock)
    if (reset) begin
      rd_q      <= 1'b0;
      vid_valid <= 1'b0;
      vid_data  <= '0;
    end else begin
      rd_q      <= vid_rd;
      vid_valid <= rd_q;
      if (rd_q) vid_data <= ram_rdata;
    end
endmodule

// File: rtl/vram_arbiter.sv
// vram_arbiter: shares one VRAM port between video fetch (strict priority) and the CPU
module vram_arbiter
  import vram_pkg::*;
#(
  parameter int ADDR_W       = VRAM_ADDR_W,
  parameter int STARVE_LIMIT = 64
) (
  input  logic                   pixel_clock,
  input  logic                   reset,
  input  logic                   vid_rd,
  input  logic [ADDR_W-1:0]      vid_addr,
  output logic [7:0]             vid_data,
  output logic                   vid_valid,
  input  logic                   cpu_req,
  input  logic                   cpu_we,
  input  logic [ADDR_W-1:0]      cpu_addr,
  input  logic [7:0]             cpu_wdata,
  output logic [7:0]             cpu_rdata,
  output logic                   cpu_ack,
  output logic                   cpu_wait,
  output logic                   cpu_starved,
  output logic [STALL_CNT_W-1:0] stall_cnt,
  output logic [ADDR_W-1:0]      ram_addr,
  output logic                   ram_we,
  output logic [7:0]             ram_wdata,
  input  logic [7:0]             ram_rdata
);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] LIM = SW'(STARVE_LIMIT);
  arb_state_t state, state_nxt;
  logic p_we, svc, deny;
  logic [ADDR_W-1:0] p_addr, addr_q;
  logic [7:0] p_wdata;
  logic [SW-1:0] starve;
  always_comb begin
    svc       = state == PEND && !vid_rd;
    deny      = state == PEND && vid_rd;
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = (cpu_req && !cpu_ack) ? PEND : IDLE;
      PEND:    state_nxt = vid_rd ? PEND : p_we ? ACK : CPU_RD;
      CPU_RD:  state_nxt = ACK;
      default: state_nxt = IDLE;
    endcase
  end
  assign cpu_ack     = state == ACK;
  assign cpu_wait    = cpu_req & ~cpu_ack;
  assign cpu_starved = starve == LIM;
  // Writes are masked during reset so an aborted access can never corrupt VRAM.
  assign ram_we      = svc & p_we & ~reset;
  assign ram_wdata   = p_wdata;
  assign ram_addr    = reset ? '0 : vid_rd ? vid_addr : svc ? p_addr : addr_q;
  always_ff @(posedge pixel_clock)
    if (reset) begin
      state     <= IDLE;
      p_we      <= 1'b0;
      p_addr    <= '0;
      p_wdata   <= '0;
      addr_q    <= '0;
      cpu_rdata <= '0;
      starve    <= '0;
      stall_cnt <= '0;
    end else begin
      state  <= state_nxt;
      addr_q <= ram_addr;
      if (state == IDLE && cpu_req) begin
        p_we    <= cpu_we;
        p_addr  <= cpu_addr;
        p_wdata <= cpu_wdata;
      end
      if (state == CPU_RD) cpu_rdata <= ram_rdata;
      if (deny && stall_cnt != '1) stall_cnt <= stall_cnt + STALL_CNT_W'(1);
      starve <= deny ? (starve == LIM ? starve : starve + SW'(1)) : (svc || cpu_ack) ? '0 : starve;
    end
  vid_fetch_pipe u_vid (
    .pixel_clock(pixel_clock),
    .reset      (reset),
    .vid_rd     (vid_rd),
    .ram_rdata  (ram_rdata),
    .vid_data   (vid_data),
    .vid_valid  (vid_valid)
  );
endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: randomized and directed checks of vram_arbiter against a transaction-level model
module tb_vram_arbiter;
  localparam int AW = 13;
  localparam int M  = 16383;
  logic pixel_clock = 1'b0;
  logic reset = 1'b1;
  logic vid_rd = 1'b0;
  logic [AW-1:0] vid_addr = '0;
  logic [7:0] vid_data;
  logic vid_valid;
  logic cpu_req = 1'b0, cpu_we = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [7:0] cpu_wdata = '0;
  logic [7:0] cpu_rdata;
  logic cpu_ack, cpu_wait, cpu_starved;
  logic [15:0] stall_cnt;
  logic [AW-1:0] ram_addr;
  logic ram_we;
  logic [7:0] ram_wdata, ram_rdata;
  bit [7:0] mem [8192];
  bit [7:0] shadow [8192];
  bit vh [16384];
  bit [7:0] vexp [16384];
  int cyc = 0, n_tests = 0, n_fail = 0;
  bit m_pend, m_we, m_ack_rd;
  logic [AW-1:0] m_addr;
  logic [7:0] m_wdata, m_rdata, m_rdo = '0, m_vdata = '0;
  int m_ack_at = -10, m_stall = 0, m_denied = 0;
  int vid_left = 0;
  bit vid_rand = 0;
  logic [AW-1:0] vid_next = '0;
  int dut_ack_cyc = 0, dut_acks = 0, first_starved = -1;

  vram_arbiter dut (
    .pixel_clock(pixel_clock), .reset(reset),
    .vid_rd(vid_rd), .vid_addr(vid_addr), .vid_data(vid_data), .vid_valid(vid_valid),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .cpu_wait(cpu_wait),
    .cpu_starved(cpu_starved), .stall_cnt(stall_cnt),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  always #5 pixel_clock = ~pixel_clock;

  always @(posedge pixel_clock) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h cycle=%0d", tag, obs, exp, cyc);
    end
  endtask

  // One clock cycle: drive video, check every output against the model, advance the model.
  task automatic tick();
    int k = cyc;
    bit exp_ack;
    if (vid_left > 0) begin
      vid_rd   = vid_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      vid_addr = vid_rand ? AW'($urandom_range(0, 15)) : vid_next;
      if (!vid_rand) vid_next = vid_next + 1'b1;
      vid_left--;
    end else vid_rd = 1'b0;
    #1;
    if (!reset) begin
      exp_ack = m_ack_at == k;
      if (exp_ack && m_ack_rd) m_rdo = m_rdata;
      if (vh[(k-2)&M]) m_vdata = vexp[(k-2)&M];
      chk("vid_valid", 32'(vid_valid), 32'(vh[(k-2)&M]));
      chk("vid_data", 32'(vid_data), 32'(m_vdata));
      chk("cpu_ack", 32'(cpu_ack), 32'(exp_ack));
      chk("cpu_wait", 32'(cpu_wait), 32'(cpu_req & ~exp_ack));
      chk("cpu_rdata", 32'(cpu_rdata), 32'(m_rdo));
      chk("cpu_starved", 32'(cpu_starved), 32'(m_denied >= 64));
      chk("stall_cnt", 32'(stall_cnt), 32'(m_stall));
      chk("ram_we", 32'(ram_we), 32'(m_pend && !vid_rd && m_we));
      if (vid_rd) chk("ram_addr_vid", 32'(ram_addr), 32'(vid_addr));
      else if (m_pend) chk("ram_addr_cpu", 32'(ram_addr), 32'(m_addr));
      if (ram_we) chk("ram_wdata", 32'(ram_wdata), 32'(m_wdata));
      if (cpu_ack) begin dut_ack_cyc = k; dut_acks++; end
      if (cpu_starved && first_starved < 0) first_starved = k;
      vh[k&M] = vid_rd;
      if (vid_rd) vexp[k&M] = shadow[vid_addr];
      if (m_pend) begin
        if (vid_rd) begin
          if (m_stall < 65535) m_stall++;
          if (m_denied < 64) m_denied++;
        end else begin
          m_pend = 0; m_denied = 0; m_ack_rd = !m_we;
          if (m_we) begin shadow[m_addr] = m_wdata; m_ack_at = k + 1; end
          else begin m_rdata = shadow[m_addr]; m_ack_at = k + 2; end
        end
      end else if (cpu_req && m_ack_at < k) begin
        m_pend = 1; m_we = cpu_we; m_addr = cpu_addr; m_wdata = cpu_wdata;
      end
    end else begin
      m_pend = 0; m_ack_at = -10; m_stall = 0; m_denied = 0;
      m_rdo = '0; m_vdata = '0; vh[k&M] = 0; vh[(k-1)&M] = 0;
    end
    @(posedge pixel_clock);
    cyc++;
    #1;
  endtask

  task automatic cpu_op(input bit we, input logic [AW-1:0] a, input logic [7:0] d, output int lat);
    int t0 = cyc;
    int prev = dut_acks;
    cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
    for (int i = 0; i < 300 && dut_acks == prev; i++) tick();
    cpu_req = 1'b0;
    lat = dut_ack_cyc - t0;
    chk("ack_once", 32'(dut_acks - prev), 32'd1);
  endtask

  task automatic do_reset();
    reset = 1'b1; tick(); reset = 1'b0;
  endtask

  initial begin
    int lat, t0, prev;
    reset = 1'b1; tick(); tick(); reset = 1'b0; tick();
    chk("rst_ack", 32'(cpu_ack), 0);
    chk("rst_rdata", 32'(cpu_rdata), 0);
    chk("rst_stall", 32'(stall_cnt), 0);
    chk("rst_we", 32'(ram_we), 0);
    chk("rst_addr", 32'(ram_addr), 0);
    chk("rst_vvalid", 32'(vid_valid), 0);
    chk("rst_starved", 32'(cpu_starved), 0);
    cpu_op(1, 13'h0123, 8'hA5, lat); chk("wr_lat", lat, 2);
    cpu_op(0, 13'h0123, 8'h00, lat); chk("rd_lat", lat, 3);
    chk("rd_data", 32'(cpu_rdata), 32'hA5);
    chk("uncont_stall", 32'(stall_cnt), 0);
    cpu_op(1, 13'h0010, 8'h11, lat);
    cpu_op(1, 13'h0021, 8'h99, lat);
    do_reset();
    vid_rand = 0; vid_next = 13'h0020; vid_left = 4;
    cpu_op(0, 13'h0010, 8'h00, lat);
    chk("coll_lat", lat, 6);
    chk("coll_stall", 32'(stall_cnt), 3);
    chk("coll_data", 32'(cpu_rdata), 32'h11);
    do_reset();
    vid_left = 70; first_starved = -1; t0 = cyc;
    cpu_op(1, 13'h1FFF, 8'h5C, lat);
    chk("starve_lat", lat, 71);
    chk("starve_rise", 32'(first_starved - t0), 65);
    chk("starve_stall", 32'(stall_cnt), 69);
    chk("starve_clear", 32'(cpu_starved), 0);
    cpu_op(1, 13'h0040, 8'h5A, lat);
    tick();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 13'h0040; tick();
    cpu_req = 1'b0; tick();
    reset = 1'b1; tick(); reset = 1'b0;
    prev = dut_acks;
    repeat (4) tick();
    chk("rst_mid_noack", 32'(dut_acks - prev), 0);
    chk("rst_mid_rdata", 32'(cpu_rdata), 0);
    chk("rst_mid_addr", 32'(ram_addr), 0);
    chk("rst_mid_stall", 32'(stall_cnt), 0);
    chk("rst_mid_mem", 32'(mem[13'h0040]), 32'h5A);
    cpu_op(0, 13'h0040, 8'h00, lat);
    chk("rst_mid_rd", 32'(cpu_rdata), 32'h5A);
    prev = dut_acks;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 13'h0077; cpu_wdata = 8'h3C; tick();
    cpu_req = 1'b0;
    repeat (10) tick();
    chk("drop_acks", 32'(dut_acks - prev), 1);
    cpu_op(0, 13'h0077, 8'h00, lat);
    chk("drop_rd", 32'(cpu_rdata), 32'h3C);
    vid_rand = 0; vid_next = '0; vid_left = 256;
    while (vid_left > 0) begin
      repeat ($urandom_range(0, 5)) tick();
      cpu_op(1'($urandom_range(0, 1)), AW'($urandom_range(0, 255)), 8'($urandom), lat);
    end
    vid_rand = 1; vid_left = 400;
    while (vid_left > 0) begin
      repeat ($urandom_range(0, 3)) tick();
      cpu_op(1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), 8'($urandom), lat);
    end
    repeat (4) tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
